// File: rtl/bomba_alternador.sv
// Duplex pump scheduler: debounces the tank level sensors, alternates the lead
// pump per fill, adds the lag pump on sustained demand and fails over on faults.
module bomba_alternador #(
    parameter int TICK_DIV      = 1000,
    parameter int DEB_TICKS     = 4,
    parameter int MIN_OFF_TICKS = 8,
    parameter int LAG_TICKS     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [2:0] sensores_i,
    input  logic [1:0] falla_i,
    output logic [1:0] bomba_o,
    output logic       alarma_o,
    output logic       lead_o,
    output logic [2:0] estado_o
);

    // state    | meaning
    // IDLE     | pumps off, waiting for an empty tank
    // RUN_LEAD | lead pump running
    // RUN_BOTH | lead and lag pumps running
    // BLOCK    | minimum off time after a fill or a cleared fault
    // FAULT    | invalid sensor code or both pumps faulted, alarm raised

    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEB_TICKS + 1);
    localparam int OW = $clog2(MIN_OFF_TICKS + 1);
    localparam int LW = $clog2(LAG_TICKS + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_TICKS);
    localparam logic [OW-1:0] OFF_LOAD  = OW'(MIN_OFF_TICKS);
    localparam logic [LW-1:0] LAG_LOAD  = LW'(LAG_TICKS);

    typedef enum logic [2:0] {
        IDLE     = 3'b000,
        RUN_LEAD = 3'b001,
        RUN_BOTH = 3'b010,
        BLOCK    = 3'b011,
        FAULT    = 3'b100
    } state_t;

    logic [2:0]    sens_meta, sens_sync;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [2:0]    cand, level;
    logic [DW-1:0] stable, stable_inc;
    logic          code_ok;

    state_t        state, state_n;
    logic          lead, lead_n;
    logic [1:0]    bomba, bomba_n;
    logic          alarma, alarma_n;
    logic [LW-1:0] lag_cnt, lag_n;
    logic [OW-1:0] off_cnt, off_n;

    assign tick       = (tick_cnt == TICK_LAST);
    assign stable_inc = (stable == DEB_MAX) ? stable : stable + DW'(1);
    assign code_ok    = (level == 3'b000) || (level == 3'b001) ||
                        (level == 3'b011) || (level == 3'b111);

    // Sensor front end resets to "full" so nothing pumps before real data is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sens_meta <= 3'b111;
            sens_sync <= 3'b111;
            tick_cnt  <= '0;
            cand      <= 3'b111;
            stable    <= '0;
            level     <= 3'b111;
        end else begin
            sens_meta <= sensores_i;
            sens_sync <= sens_meta;
            tick_cnt  <= tick ? '0 : tick_cnt + TW'(1);
            if (tick) begin
                if (sens_sync == cand) begin
                    stable <= stable_inc;
                    if (stable_inc == DEB_MAX)
                        level <= cand;
                end else begin
                    cand   <= sens_sync;
                    stable <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            lead    <= 1'b0;
            bomba   <= 2'b00;
            alarma  <= 1'b0;
            lag_cnt <= '0;
            off_cnt <= '0;
        end else begin
            state   <= state_n;
            lead    <= lead_n;
            bomba   <= bomba_n;
            alarma  <= alarma_n;
            lag_cnt <= lag_n;
            off_cnt <= off_n;
        end
    end

    always_comb begin
        state_n = state;
        lead_n  = lead;
        lag_n   = lag_cnt;
        off_n   = off_cnt;

        if (tick && (state == RUN_LEAD) && (lag_cnt != '0))
            lag_n = lag_cnt - LW'(1);
        if (tick && (state == BLOCK) && (off_cnt != '0))
            off_n = off_cnt - OW'(1);

        if (!code_ok || (falla_i == 2'b11)) begin
            state_n = FAULT;
        end else if (!ena && (state != FAULT)) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (level == 3'b000) begin
                        state_n = RUN_LEAD;
                        lag_n   = LAG_LOAD;
                    end
                end
                RUN_LEAD: begin
                    if (level == 3'b111) begin
                        state_n = BLOCK;
                        lead_n  = ~lead;
                        off_n   = OFF_LOAD;
                    end else if (falla_i[lead]) begin
                        lead_n = ~lead;
                        lag_n  = LAG_LOAD;
                    end else if ((lag_cnt == '0) && !level[1] && (falla_i == 2'b00)) begin
                        state_n = RUN_BOTH;
                    end
                end
                RUN_BOTH: begin
                    if (level == 3'b111) begin
                        state_n = BLOCK;
                        lead_n  = ~lead;
                        off_n   = OFF_LOAD;
                    end else if (falla_i[0] ^ falla_i[1]) begin
                        // the healthy pump is pump 1 exactly when pump 0 is faulted
                        state_n = RUN_LEAD;
                        lead_n  = falla_i[0];
                        lag_n   = LAG_LOAD;
                    end
                end
                BLOCK: begin
                    if (off_cnt == '0)
                        state_n = IDLE;
                end
                FAULT: begin
                    if (falla_i == 2'b00) begin
                        state_n = BLOCK;
                        off_n   = OFF_LOAD;
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        case (state_n)
            RUN_LEAD: bomba_n = lead_n ? 2'b10 : 2'b01;
            RUN_BOTH: bomba_n = 2'b11;
            default:  bomba_n = 2'b00;
        endcase
        alarma_n = (state_n == FAULT);
    end

    assign bomba_o  = bomba;
    assign alarma_o = alarma;
    assign lead_o   = lead;
    assign estado_o = state;

endmodule
